// File: rtl/rf_wb_sched.sv
// Register-file writeback scheduler: busy-bit scoreboard for issue hazards plus a
// round-robin arbiter merging ALU and load-unit writebacks onto one write port.
module rf_wb_sched (
  input  logic        clk_i,
  input  logic        rst_ni,
  input  logic        iss_valid_i,
  input  logic [4:0]  iss_rd_i,
  input  logic [4:0]  iss_rs1_i,
  input  logic [4:0]  iss_rs2_i,
  output logic        iss_stall_o,
  input  logic        alu_valid_i,
  input  logic [4:0]  alu_rd_i,
  input  logic [31:0] alu_data_i,
  output logic        alu_ready_o,
  input  logic        mem_valid_i,
  input  logic [4:0]  mem_rd_i,
  input  logic [31:0] mem_data_i,
  output logic        mem_ready_o,
  output logic        rf_w_enable_o,
  output logic [4:0]  rf_w_addr_o,
  output logic [31:0] rf_w_data_o,
  output logic [5:0]  pend_cnt_o,
  output logic        wb_err_o
);

  typedef enum logic {
    LAST_ALU = 1'b0,
    LAST_MEM = 1'b1
  } rr_e;

  rr_e         rr_q, rr_d;
  logic [31:0] busy_q, busy_d;
  logic [5:0]  pend_q, pend_d;
  logic        wb_err_q, wb_err_d;
  logic        wen_q, wen_d;
  logic [4:0]  waddr_q, waddr_d;
  logic [31:0] wdata_q, wdata_d;

  logic        alu_gnt, mem_gnt, gnt_any, iss_accept;
  logic [4:0]  gnt_rd;
  logic [31:0] gnt_data;

  assign iss_stall_o = iss_valid_i &
                       (busy_q[iss_rs1_i] | busy_q[iss_rs2_i] | busy_q[iss_rd_i]);
  assign iss_accept  = iss_valid_i & ~iss_stall_o;

  // Under contention the side that did not win the most recent grant goes next.
  always_comb begin
    alu_gnt = 1'b0;
    mem_gnt = 1'b0;
    if (rst_ni) begin
      if (alu_valid_i && mem_valid_i) begin
        if (rr_q == LAST_ALU) mem_gnt = 1'b1;
        else                  alu_gnt = 1'b1;
      end else if (alu_valid_i) begin
        alu_gnt = 1'b1;
      end else if (mem_valid_i) begin
        mem_gnt = 1'b1;
      end
    end
  end

  assign alu_ready_o = alu_gnt;
  assign mem_ready_o = mem_gnt;
  assign gnt_any     = alu_gnt | mem_gnt;
  assign gnt_rd      = alu_gnt ? alu_rd_i   : mem_rd_i;
  assign gnt_data    = alu_gnt ? alu_data_i : mem_data_i;

  always_comb begin
    rr_d     = rr_q;
    wen_d    = 1'b0;
    waddr_d  = waddr_q;
    wdata_d  = wdata_q;
    wb_err_d = wb_err_q;
    busy_d   = busy_q;
    pend_d   = '0;

    if (alu_gnt) rr_d = LAST_ALU;
    if (mem_gnt) rr_d = LAST_MEM;

    if (gnt_any) begin
      wen_d   = (gnt_rd != 5'd0);
      waddr_d = gnt_rd;
      wdata_d = gnt_data;
      if ((gnt_rd != 5'd0) && !busy_q[gnt_rd]) wb_err_d = 1'b1;
    end

    // The clear is applied after the set so it wins on a same-bit collision.
    if (iss_accept && (iss_rd_i != 5'd0)) busy_d[iss_rd_i] = 1'b1;
    if (wen_q) busy_d[waddr_q] = 1'b0;
    busy_d[0] = 1'b0;

    for (int i = 1; i < 32; i++) begin
      pend_d = pend_d + 6'(busy_d[i]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      rr_q     <= LAST_ALU;
      busy_q   <= '0;
      pend_q   <= '0;
      wb_err_q <= 1'b0;
      wen_q    <= 1'b0;
      waddr_q  <= '0;
      wdata_q  <= '0;
    end else begin
      rr_q     <= rr_d;
      busy_q   <= busy_d;
      pend_q   <= pend_d;
      wb_err_q <= wb_err_d;
      wen_q    <= wen_d;
      waddr_q  <= waddr_d;
      wdata_q  <= wdata_d;
    end
  end

  assign rf_w_enable_o = wen_q;
  assign rf_w_addr_o   = waddr_q;
  assign rf_w_data_o   = wdata_q;
  assign pend_cnt_o    = pend_q;
  assign wb_err_o      = wb_err_q;

endmodule

// File: tb/tb_rf_wb_sched.sv
// Randomized and directed bench for rf_wb_sched, checked against a per-cycle
// behavioural model of the scoreboard, arbiter and write port.
module tb_rf_wb_sched;

  logic        clk;
  logic        rst_n;
  logic        issValid;
  logic [4:0]  issRd, issRs1, issRs2;
  logic        issStall;
  logic        aluValid;
  logic [4:0]  aluRd;
  logic [31:0] aluData;
  logic        aluReady;
  logic        memValid;
  logic [4:0]  memRd;
  logic [31:0] memData;
  logic        memReady;
  logic        rfWen;
  logic [4:0]  rfWaddr;
  logic [31:0] rfWdata;
  logic [5:0]  pendCnt;
  logic        wbErr;

  int checkCount = 0;
  int errorCount = 0;

  // Reference state: what the register scoreboard and write port should hold.
  bit          mBusy[32];
  bit          mLastMem;
  bit          mErr;
  bit          mWen;
  logic [4:0]  mAddr;
  logic [31:0] mData;

  logic        obsStall, obsAluRdy, obsMemRdy, obsWen, obsErr;
  logic [4:0]  obsAddr;
  logic [31:0] obsData;
  logic [5:0]  obsPend;

  rf_wb_sched dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .iss_valid_i   (issValid),
    .iss_rd_i      (issRd),
    .iss_rs1_i     (issRs1),
    .iss_rs2_i     (issRs2),
    .iss_stall_o   (issStall),
    .alu_valid_i   (aluValid),
    .alu_rd_i      (aluRd),
    .alu_data_i    (aluData),
    .alu_ready_o   (aluReady),
    .mem_valid_i   (memValid),
    .mem_rd_i      (memRd),
    .mem_data_i    (memData),
    .mem_ready_o   (memReady),
    .rf_w_enable_o (rfWen),
    .rf_w_addr_o   (rfWaddr),
    .rf_w_data_o   (rfWdata),
    .pend_cnt_o    (pendCnt),
    .wb_err_o      (wbErr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checkCount++;
    if (obs !== exp) begin
      errorCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic modelReset();
    for (int i = 0; i < 32; i++) mBusy[i] = 1'b0;
    mLastMem = 1'b0;
    mErr     = 1'b0;
    mWen     = 1'b0;
    mAddr    = '0;
    mData    = '0;
  endtask

  function automatic int modelPend();
    int n = 0;
    for (int i = 0; i < 32; i++) n += int'(mBusy[i]);
    return n;
  endfunction

  // One clock cycle: drive, check combinational outputs, clock, check registered outputs.
  task automatic applyStimulus(
    input logic r, input logic iv, input logic [4:0] ird, input logic [4:0] irs1,
    input logic [4:0] irs2, input logic av, input logic [4:0] ard, input logic [31:0] adat,
    input logic mv, input logic [4:0] mrd, input logic [31:0] mdat);
    bit expStall, expAlu, expMem, gnt, newErr;
    logic [4:0]  grd;
    logic [31:0] gdat;
    rst_n = r; issValid = iv; issRd = ird; issRs1 = irs1; issRs2 = irs2;
    aluValid = av; aluRd = ard; aluData = adat;
    memValid = mv; memRd = mrd; memData = mdat;
    #1;
    expStall = iv && (mBusy[irs1] || mBusy[irs2] || mBusy[ird]);
    expAlu = 1'b0;
    expMem = 1'b0;
    if (r) begin
      if (av && mv) begin
        expAlu = mLastMem;
        expMem = !mLastMem;
      end else begin
        expAlu = av;
        expMem = mv;
      end
    end
    obsStall = issStall; obsAluRdy = aluReady; obsMemRdy = memReady;
    checkOutput("iss_stall", 32'(obsStall), 32'(expStall));
    checkOutput("alu_ready", 32'(obsAluRdy), 32'(expAlu));
    checkOutput("mem_ready", 32'(obsMemRdy), 32'(expMem));
    @(posedge clk);
    if (!r) begin
      modelReset();
    end else begin
      gnt  = expAlu || expMem;
      grd  = expAlu ? ard : mrd;
      gdat = expAlu ? adat : mdat;
      newErr = mErr || (gnt && grd != 5'd0 && !mBusy[grd]);
      if (iv && !expStall && ird != 5'd0) mBusy[ird] = 1'b1;
      if (mWen) mBusy[mAddr] = 1'b0;
      if (expAlu) mLastMem = 1'b0;
      if (expMem) mLastMem = 1'b1;
      mErr = newErr;
      mWen = gnt && grd != 5'd0;
      if (mWen) begin
        mAddr = grd;
        mData = gdat;
      end
    end
    #1;
    obsWen = rfWen; obsAddr = rfWaddr; obsData = rfWdata; obsPend = pendCnt; obsErr = wbErr;
    checkOutput("rf_w_enable", 32'(obsWen), 32'(mWen));
    if (mWen) begin
      checkOutput("rf_w_addr", 32'(obsAddr), 32'(mAddr));
      checkOutput("rf_w_data", obsData, mData);
    end
    checkOutput("pend_cnt", 32'(obsPend), 32'(modelPend()));
    checkOutput("wb_err", 32'(obsErr), 32'(mErr));
  endtask

  task automatic idleCycle(input logic r);
    applyStimulus(r, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst_n = 1'b0; issValid = 0; issRd = 0; issRs1 = 0; issRs2 = 0;
    aluValid = 0; aluRd = 0; aluData = 0; memValid = 0; memRd = 0; memData = 0;
    repeat (2) @(posedge clk);
    #1;
    modelReset();

    // Reset state and RAW hazard through a full ALU writeback.
    idleCycle(0);
    checkOutput("reset_pend", 32'(obsPend), 32'd0);
    checkOutput("reset_wen", 32'(obsWen), 32'd0);
    applyStimulus(1, 1, 5, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r030_pend1", 32'(obsPend), 32'd1);
    applyStimulus(1, 1, 6, 5, 0, 1, 5, 32'hDEADBEEF, 0, 0, 0);
    checkOutput("r030_stall", 32'(obsStall), 32'd1);
    checkOutput("r030_wen", 32'(obsWen), 32'd1);
    checkOutput("r030_addr", 32'(obsAddr), 32'd5);
    checkOutput("r030_data", obsData, 32'hDEADBEEF);
    applyStimulus(1, 1, 6, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r030_stall_wcycle", 32'(obsStall), 32'd1);
    applyStimulus(1, 1, 6, 5, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r030_stall_clear", 32'(obsStall), 32'd0);
    idleCycle(0);

    // Contended writebacks alternate, MEM first after reset.
    applyStimulus(1, 1, 3, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 1, 4, 0, 0, 0, 0, 0, 0, 0, 0);
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 32'h33, 1, 4, 32'h44);
    checkOutput("r031_g1_mem", 32'({obsAluRdy, obsMemRdy}), 32'b01);
    applyStimulus(1, 0, 0, 0, 0, 1, 3, 32'h33, 1, 3, 32'h3);
    checkOutput("r031_g2_alu", 32'({obsAluRdy, obsMemRdy}), 32'b10);
    applyStimulus(1, 0, 0, 0, 0, 1, 4, 32'h4, 1, 3, 32'h3);
    checkOutput("r031_g3_mem", 32'({obsAluRdy, obsMemRdy}), 32'b01);
    idleCycle(0);

    // x0 is never tracked and never written.
    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r032_pend", 32'(obsPend), 32'd0);
    applyStimulus(1, 0, 0, 0, 0, 1, 0, 32'h1234, 0, 0, 0);
    checkOutput("r032_wen", 32'(obsWen), 32'd0);
    checkOutput("r032_err", 32'(obsErr), 32'd0);

    // Writeback to an idle register flags a sticky error but still writes.
    applyStimulus(1, 0, 0, 0, 0, 1, 7, 32'h77, 0, 0, 0);
    checkOutput("r033_err", 32'(obsErr), 32'd1);
    checkOutput("r033_addr", 32'(obsAddr), 32'd7);
    idleCycle(1);
    idleCycle(1);
    checkOutput("r033_err_hold", 32'(obsErr), 32'd1);
    idleCycle(0);
    checkOutput("r033_err_clr", 32'(obsErr), 32'd0);

    // Fill the scoreboard, then reset with a pending MEM request.
    for (int i = 1; i < 32; i++) applyStimulus(1, 1, 5'(i), 0, 0, 0, 0, 0, 0, 0, 0);
    checkOutput("r034_full", 32'(obsPend), 32'd31);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1, 9, 32'h99);
    checkOutput("r034_mem_ready", 32'(obsMemRdy), 32'd0);
    checkOutput("r034_pend", 32'(obsPend), 32'd0);
    idleCycle(1);
    checkOutput("r034_no_write", 32'(obsWen), 32'd0);

    // Random traffic over a small register window to provoke hazards and contention.
    for (int c = 0; c < 600; c++) begin
      applyStimulus($urandom_range(0, 49) != 0,
                    $urandom_range(0, 1) == 1, 5'($urandom_range(0, 7)),
                    5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
                    $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom,
                    $urandom_range(0, 2) == 0, 5'($urandom_range(0, 7)), $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

endmodule

// File: doc/rf_wb_sched.md
RF_WB_SCHED -- requirements
Module: rf_wb_sched

Interface
REQ-001 SHALL have clk, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL have rst_n, input, 1, synchronous active-low reset, sampled on the rising edge of clk.
REQ-003 SHALL have iss_valid (input, 1), iss_rd (input, 5), iss_rs1 (input, 5), iss_rs2 (input, 5): the decode-stage instruction under hazard check.
REQ-004 SHALL have iss_stall, output, 1: the instruction on iss_* is held and not accepted this cycle.
REQ-005 SHALL have alu_valid (input, 1), alu_rd (input, 5), alu_data (input, 32), alu_ready (output, 1): the ALU writeback requester.
REQ-006 SHALL have mem_valid (input, 1), mem_rd (input, 5), mem_data (input, 32), mem_ready (output, 1): the load-unit writeback requester.
REQ-007 SHALL have rf_w_enable (output, 1), rf_w_addr (output, 5), rf_w_data (output, 32): drives the single register-file write port.
REQ-008 SHALL have pend_cnt, output, 6: the number of registers currently marked busy.
REQ-009 SHALL have wb_err, output, 1: sticky flag for a writeback to a register that is not busy.

Function
REQ-010 SHALL hold a 32-bit busy vector, one bit per register; bit 0 SHALL be constant 0.
REQ-011 SHALL drive iss_stall = iss_valid AND (busy[iss_rs1] OR busy[iss_rs2] OR busy[iss_rd]), purely combinationally (RAW and WAW protection).
REQ-012 SHALL treat an issue as accepted when iss_valid=1 and iss_stall=0; on acceptance with iss_rd≠0, SHALL set busy[iss_rd] at the next edge.
REQ-013 SHALL treat a writeback handshake as complete when valid and ready are both 1 on the same edge.
REQ-014 SHALL assert at most one of alu_ready and mem_ready per cycle.
REQ-015 SHALL grant the only valid requester when exactly one of alu_valid and mem_valid is 1.
REQ-016 SHALL arbitrate round-robin when both requesters are valid: grant the requester not granted on the most recent grant.
REQ-017 SHALL leave the round-robin pointer unchanged in cycles with no grant.
REQ-018 SHALL deassert alu_ready and mem_ready when neither requester is valid.
REQ-019 SHALL register the granted rd and data into rf_w_addr/rf_w_data, with rf_w_enable=1, on the edge that completes the handshake: 1-cycle latency from grant to the write port.
REQ-020 SHALL drive rf_w_enable=0 in the cycle after a grant whose rd=0; rf_w_addr and rf_w_data are don't-care in that cycle.
REQ-021 SHALL clear busy[rf_w_addr] on the edge at which rf_w_enable=1 is presented, so that a combinational regfile read is valid in the cycle busy drops.
REQ-022 SHALL keep busy asserted during the rf_w_enable cycle; an issue reading that register SHALL stall in that cycle.
REQ-023 SHALL give clear priority over set if a set and a clear target the same bit on the same edge (unreachable by REQ-011; defensive).
REQ-024 SHALL set wb_err, and keep it set until reset, when a grant carries rd≠0 whose busy bit is 0; the write SHALL still be performed.
REQ-025 SHALL maintain pend_cnt as the population count of the busy vector, updated on the same edge as the vector: +1 for a set, -1 for a clear, unchanged for both or neither; range 0..31.
REQ-026 SHALL keep requesters independent of issue: iss_stall does not affect writeback grants.

Reset
REQ-027 SHALL, on any edge with rst_n=0, clear the busy vector, pend_cnt, wb_err and rf_w_enable, and set the round-robin pointer so that MEM wins the first contended grant.
REQ-028 SHALL force alu_ready=0 and mem_ready=0 while rst_n=0.
REQ-029 SHALL discard a grant or issue that occurs mid-operation in a reset cycle: no rf write follows it and no busy bit is set.

Verification
REQ-030 Issue rd=5 accepted; next cycle issue rs1=5 -> iss_stall=1; ALU writes rd=5 with data 0xDEADBEEF -> next cycle rf_w_enable=1, rf_w_addr=5, rf_w_data=0xDEADBEEF; following cycle iss_stall=0 and pend_cnt back to 0.
REQ-031 After reset, busy 3 and 4, both requesters valid for 3 cycles (ALU rd=3 then 4, MEM rd=4 then 3) -> grants in order MEM, ALU, MEM; exactly one ready per cycle.
REQ-032 Issue rd=0 -> no busy bit set, pend_cnt=0; ALU writeback rd=0 -> rf_w_enable=0 next cycle, wb_err stays 0.
REQ-033 ALU writeback rd=7 while busy[7]=0 -> wb_err=1 and write to register 7 occurs; wb_err holds until rst_n=0.
REQ-034 Registers 1..31 busy (pend_cnt=31), then rst_n=0 for one cycle while MEM valid -> mem_ready=0, busy cleared, pend_cnt=0, no rf write follows.
